// File: rtl/nibble_serial_subtractor_16bit.sv
// Bit-serial (slice-per-clock) subtractor: Diff = A - B, one SLICE-bit slice per cycle,
// LSB slice first, borrow carried between cycles as an inverted carry (A + ~B + 1).
module nibble_serial_subtractor_16bit #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow,
   output logic             Overflow
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d, borrow_q, borrow_d, ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [SLICE-1:0] a_slice, b_slice, sum_slice;
   logic             carry_out;

   always_comb begin
      a_slice = a_q[cnt_q*SLICE +: SLICE];
      b_slice = nb_q[cnt_q*SLICE +: SLICE];
      {carry_out, sum_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      nb_d     = nb_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               nb_d    = ~B;
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            diff_d[cnt_q*SLICE +: SLICE] = sum_slice;
            carry_d = carry_out;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               borrow_d = ~carry_out;
               // Operand signs differ iff A's MSB equals the MSB of the stored ~B.
               ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum_slice[SLICE-1] != a_q[WIDTH-1]);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Operand registers carry data only; they are reloaded on every accept.
   always_ff @(posedge clk) begin
      a_q  <= a_d;
      nb_q <= nb_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Diff      = diff_q;
   assign Borrow    = borrow_q;
   assign Overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor_16bit.sv
// Scoreboard bench for nibble_serial_subtractor_16bit: directed corner cases, backpressure,
// mid-operation reset and randomized traffic against a plain-arithmetic reference model.
module tb_nibble_serial_subtractor_16bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] A = '0, B = '0;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Diff;
   logic        Borrow, Overflow;

   nibble_serial_subtractor_16bit #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .out_valid(out_valid), .out_ready(out_ready), .Diff(Diff), .Borrow(Borrow),
      .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] diff;
      logic        borrow;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, passed = 0;
   int   accepts = 0, results = 0;
   bit   rand_ready = 1'b0;
   bit   ready_force = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   sd;
      e.diff   = 16'((int'(a) - int'(b) + 65536) % 65536);
      e.borrow = (int'(a) < int'(b));
      sd       = int'($signed(a)) - int'($signed(b));
      e.ovf    = (sd > 32767) || (sd < -32768);
      return e;
   endfunction

   // Consumer-side ready, changed just after the rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Monitor: a transfer happens at the next rising edge when valid and ready are both high here.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            results++;
            if (exp_q.size() == 0) begin
               check("spurious_result", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("diff", 32'(Diff), 32'(e.diff));
               check("borrow", 32'(Borrow), 32'(e.borrow));
               check("overflow", 32'(Overflow), 32'(e.ovf));
            end
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      A = a; B = b; in_valid = 1'b1;
      for (int n = 0; n < 60; n++) begin
         if (in_ready) begin
            exp_q.push_back(model(a, b));
            accepts++;
            @(posedge clk);
            #1 in_valid = 1'b0;
            A = 16'($urandom); B = 16'($urandom);
            return;
         end
         @(negedge clk);
      end
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 400; n++) begin
         if (exp_q.size() == 0 && !out_valid) return;
         @(negedge clk);
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] held;
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held_diff;
      logic [15:0] ra, rb;
      int          gap;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(Diff), 32'd0);
      check("rst_borrow", 32'(Borrow), 32'd0);
      check("rst_overflow", 32'(Overflow), 32'd0);

      // Latency: out_valid first visible after the fourth edge following acceptance.
      issue(16'h1234, 16'h0234);
      repeat (4) @(negedge clk);
      check("latency_not_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("latency_valid", 32'(out_valid), 32'd1);
      drain();

      issue(16'h0000, 16'h0001); drain();
      issue(16'h8000, 16'h0001); drain();
      issue(16'h7FFF, 16'hFFFF); drain();
      issue(16'hFFFF, 16'hFFFF); drain();

      // Backpressure: result must hold and new operands must be ignored.
      ready_force = 1'b0;
      issue(16'hABCD, 16'h1234);
      for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
      check("bp_reached_done", 32'(out_valid), 32'd1);
      held_diff = Diff;
      in_valid = 1'b1; A = 16'h0005; B = 16'h0001;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_diff_stable", 32'(Diff), 32'(held_diff));
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      ready_force = 1'b1;
      drain();
      check("bp_idle_after", 32'(in_ready), 32'd1);

      // Reset during the second CALC cycle aborts the operation.
      issue(16'h4321, 16'h1111);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      accepts--;
      @(negedge clk);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff", 32'(Diff), 32'd0);
      repeat (8) @(negedge clk);
      check("abort_no_result", 32'(out_valid), 32'd0);
      issue(16'd5, 16'd3); drain();

      // Randomized traffic with random input gaps and random consumer stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 7))
            0: begin ra = 16'h8000; rb = 16'($urandom); end
            1: begin ra = 16'($urandom); rb = 16'hFFFF; end
            2: begin ra = 16'($urandom); rb = ra; end
            default: begin ra = 16'($urandom); rb = 16'($urandom); end
         endcase
         issue(ra, rb);
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
      end
      drain();
      rand_ready = 1'b0;
      check("result_count", 32'(results), 32'(accepts));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
